// File: rtl/blink_cmd_rx_if.sv
// Host-facing serial link and blinker configuration bus for blink_cmd_rx.
// slave = the receiver itself, master = whatever drives uart_rx and consumes the config.
interface blink_cmd_rx_if;
    logic        uart_rx;
    logic        uart_tx;
    logic [31:0] on_ticks;
    logic [31:0] off_ticks;
    logic [7:0]  led_mask;
    logic        cfg_update;
    logic        err;

    modport master (
        output uart_rx,
        input  uart_tx, on_ticks, off_ticks, led_mask, cfg_update, err
    );

    modport slave (
        input  uart_rx,
        output uart_tx, on_ticks, off_ticks, led_mask, cfg_update, err
    );
endinterface

// File: rtl/blink_cmd_rx.sv
// UART 8N1 command receiver feeding the LED blinker configuration registers.
// Optional ACK/NAK echo transmitter is enabled by defining BLINK_CMD_ECHO_EN.
module blink_cmd_rx #(
    parameter int CLK_FREQ     = 25_000_000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20,
    parameter int DEF_ON       = CLK_FREQ * 9 / 10,
    parameter int DEF_OFF      = CLK_FREQ * 2 / 10
) (
    input logic           clk,
    input logic           rst_n,
    blink_cmd_rx_if.slave bus
);
    localparam int CPB    = CLK_FREQ / BAUD;
    localparam int HALF   = CPB / 2;
    localparam int TO_LIM = TIMEOUT_BITS * CPB;
    localparam int BW     = $clog2(CPB + 1);
    localparam int TW     = $clog2(TO_LIM + 1);

    localparam logic [31:0] ON_RST   = 32'(DEF_ON);
    localparam logic [31:0] OFF_RST  = 32'(DEF_OFF);
    localparam logic [7:0]  MASK_RST = 8'h01;
    localparam logic [7:0]  HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
    typedef enum logic [1:0] {P_HDR, P_CMD, P_DATA, P_CHK} pkt_state_t;

    function automatic logic [31:0] min1(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    // ---------------- input synchronizer ----------------
    logic [1:0] rx_sync;
    logic       rx_prev;
    logic       rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], bus.uart_rx};
            rx_prev <= rx_sync[1];
        end
    end

    assign rx = rx_sync[1];

    // ---------------- byte receiver ----------------
    rx_state_t       rx_st;
    logic [BW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      rx_shift;
    logic            byte_stb;
    logic            frm_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st    <= R_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            frm_err  <= 1'b0;
            case (rx_st)
                R_IDLE: begin
                    if (rx_prev && !rx) begin
                        rx_st   <= R_START;
                        bit_cnt <= '0;
                    end
                end
                R_START: begin
                    if (bit_cnt == BW'(HALF - 1)) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        rx_st   <= rx ? R_IDLE : R_DATA;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                R_DATA: begin
                    if (bit_cnt == BW'(CPB - 1)) begin
                        bit_cnt  <= '0;
                        rx_shift <= {rx, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            rx_st <= R_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                R_STOP: begin
                    if (bit_cnt == BW'(CPB - 1)) begin
                        bit_cnt <= '0;
                        if (rx) begin
                            byte_stb <= 1'b1;
                            rx_st    <= R_IDLE;
                        end else begin
                            frm_err <= 1'b1;
                            rx_st   <= R_BREAK;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                // line held low after a bad stop bit: wait for idle before hunting again
                R_BREAK: if (rx) rx_st <= R_IDLE;
                default: rx_st <= R_IDLE;
            endcase
        end
    end

    // ---------------- packet decoder and config registers ----------------
    pkt_state_t      pkt_st;
    logic [7:0]      cmd;
    logic [31:0]     data;
    logic [1:0]      dcnt;
    logic [7:0]      xsum;
    logic [TW-1:0]   gap;
    logic [31:0]     on_r, off_r;
    logic [7:0]      mask_r;
    logic            cfg_r, err_r;
    logic            ack_req, nak_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_st  <= P_HDR;
            cmd     <= '0;
            data    <= '0;
            dcnt    <= '0;
            xsum    <= '0;
            gap     <= '0;
            on_r    <= ON_RST;
            off_r   <= OFF_RST;
            mask_r  <= MASK_RST;
            cfg_r   <= 1'b0;
            err_r   <= 1'b0;
            ack_req <= 1'b0;
            nak_req <= 1'b0;
        end else begin
            cfg_r   <= 1'b0;
            err_r   <= frm_err;
            ack_req <= 1'b0;
            nak_req <= 1'b0;
            if (byte_stb) begin
                gap <= '0;
                case (pkt_st)
                    P_HDR: if (rx_shift == HDR_BYTE) pkt_st <= P_CMD;
                    P_CMD: begin
                        cmd    <= rx_shift;
                        xsum   <= rx_shift;
                        dcnt   <= '0;
                        pkt_st <= P_DATA;
                    end
                    P_DATA: begin
                        data <= {data[23:0], rx_shift};
                        xsum <= xsum ^ rx_shift;
                        dcnt <= dcnt + 2'd1;
                        if (dcnt == 2'd3)
                            pkt_st <= P_CHK;
                    end
                    P_CHK: begin
                        pkt_st <= P_HDR;
                        if (rx_shift != xsum) begin
                            err_r   <= 1'b1;
                            nak_req <= 1'b1;
                        end else begin
                            cfg_r   <= 1'b1;
                            ack_req <= 1'b1;
                            case (cmd)
                                8'h01: on_r   <= min1(data);
                                8'h02: off_r  <= min1(data);
                                8'h03: mask_r <= data[7:0];
                                8'h04: begin
                                    on_r   <= ON_RST;
                                    off_r  <= OFF_RST;
                                    mask_r <= MASK_RST;
                                end
                                default: begin
                                    cfg_r   <= 1'b0;
                                    ack_req <= 1'b0;
                                    err_r   <= 1'b1;
                                    nak_req <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: pkt_st <= P_HDR;
                endcase
            end else if (pkt_st != P_HDR) begin
                // inter-byte gap watchdog: a stalled host must not wedge the decoder
                if (gap == TW'(TO_LIM)) begin
                    pkt_st <= P_HDR;
                    gap    <= '0;
                end else begin
                    gap <= gap + TW'(1);
                end
            end
        end
    end

    assign bus.on_ticks   = on_r;
    assign bus.off_ticks  = off_r;
    assign bus.led_mask   = mask_r;
    assign bus.cfg_update = cfg_r;
    assign bus.err        = err_r;

    // ---------------- optional echo transmitter ----------------
`ifdef BLINK_CMD_ECHO_EN
    logic [8:0]    tx_shift;
    logic [3:0]    tx_bits;
    logic [BW-1:0] tx_cnt;
    logic          tx_busy;
    logic          tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '1;
            tx_bits  <= '0;
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_q     <= 1'b1;
        end else if (!tx_busy) begin
            if (ack_req || nak_req) begin
                tx_shift <= {1'b1, (ack_req ? 8'h06 : 8'h15)};
                tx_bits  <= '0;
                tx_cnt   <= '0;
                tx_busy  <= 1'b1;
                tx_q     <= 1'b0;
            end
        end else if (tx_cnt == BW'(CPB - 1)) begin
            tx_cnt <= '0;
            if (tx_bits == 4'd9) begin
                tx_busy <= 1'b0;
                tx_q    <= 1'b1;
            end else begin
                tx_q     <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bits  <= tx_bits + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + BW'(1);
        end
    end

    assign bus.uart_tx = tx_q;
`else
    logic unused_req;
    assign unused_req  = ack_req ^ nak_req;
    assign bus.uart_tx = 1'b1;
`endif

endmodule
